// File: rtl/mem_arbiter_if.sv
// Signal bundle for the shared main-memory port: cache miss requests, the memory strobes,
// and the fill/done/stall returns to the pipeline.
interface mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int LINE_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_dirty;
  logic [ADDR_W-1:0] d_wb_addr;
  logic [LINE_W-1:0] d_wb_data;
  logic [LINE_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [LINE_W-1:0] fill_data;
  logic              i_done;
  logic              d_done;
  logic              stall_if;
  logic              stall_mem;

  // Client side: the two caches plus the memory's read-data return.
  modport master (
    output i_req, i_addr, d_req, d_addr, d_dirty, d_wb_addr, d_wb_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, fill_data, i_done, d_done, stall_if, stall_mem
  );

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_dirty, d_wb_addr, d_wb_data, mem_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_wr, fill_data, i_done, d_done, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter: D-cache (writeback + fill) has priority over I-cache fills;
// each access holds its strobe for MEM_LAT cycles and the filled line is returned with a done pulse.
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 14,
  parameter int LINE_W  = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int                CNT_W     = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [LINE_W-1:0] LINE_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL_D,
    S_FILL_I,
    S_DONE_D,
    S_DONE_I
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_d_addr;
  logic              w_last;

  assign w_last        = (r_cnt == CNT_ONE);
  assign bus.stall_if  = bus.i_req & ~bus.i_done;
  assign bus.stall_mem = bus.d_req & ~bus.d_done;

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        // D is the older instruction, so it wins any tie with I.
        if (bus.d_req)      w_state_next = bus.d_dirty ? S_WB : S_FILL_D;
        else if (bus.i_req) w_state_next = S_FILL_I;
      end
      S_WB:     if (w_last) w_state_next = S_FILL_D;
      S_FILL_D: if (w_last) w_state_next = S_DONE_D;
      S_FILL_I: if (w_last) w_state_next = S_DONE_I;
      S_DONE_D,
      S_DONE_I: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_d_addr      <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= LINE_ZERO;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.fill_data <= LINE_ZERO;
      bus.i_done    <= 1'b0;
      bus.d_done    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      // Strobes and done pulses are decoded from the next state so they align with it.
      bus.mem_rd <= (w_state_next == S_FILL_D) || (w_state_next == S_FILL_I);
      bus.mem_wr <= (w_state_next == S_WB);
      bus.d_done <= (w_state_next == S_DONE_D);
      bus.i_done <= (w_state_next == S_DONE_I);

      case (r_state)
        S_IDLE: begin
          if (w_state_next != S_IDLE) r_cnt <= CNT_LOAD;
          if (w_state_next == S_WB) begin
            bus.mem_addr  <= bus.d_wb_addr;
            bus.mem_wdata <= bus.d_wb_data;
            r_d_addr      <= bus.d_addr;
          end else if (w_state_next == S_FILL_D) begin
            bus.mem_addr  <= bus.d_addr;
          end else if (w_state_next == S_FILL_I) begin
            bus.mem_addr  <= bus.i_addr;
          end
        end
        S_WB: begin
          if (w_last) begin
            r_cnt        <= CNT_LOAD;
            bus.mem_addr <= r_d_addr;
          end else begin
            r_cnt        <= r_cnt - CNT_ONE;
          end
        end
        S_FILL_D,
        S_FILL_I: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (w_last) bus.fill_data <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked against a
// cycle-plan reference model built from the transaction rules.
module tb_mem_arbiter;
  localparam int L  = 4;
  localparam int AW = 14;
  localparam int LW = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus  ();
  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus1 ();

  mem_arbiter #(.MEM_LAT(L), .ADDR_W(AW), .LINE_W(LW)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mem_arbiter #(.MEM_LAT(1), .ADDR_W(AW), .LINE_W(LW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue holding the expected outputs of each future cycle.
  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          idone;
    logic          ddone;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } exp_t;

  exp_t          plan[$];
  exp_t          m_e;
  logic [LW-1:0] prev_rdata = '0;

  task automatic push_burst(input logic rd, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    exp_t e;
    e = '0; e.rd = rd; e.wr = ~rd; e.addr = a; e.wdata = wd;
    for (int k = 0; k < L; k++) plan.push_back(e);
  endtask

  task automatic push_done(input logic is_i);
    exp_t e;
    e = '0; e.idone = is_i; e.ddone = ~is_i;
    plan.push_back(e);
  endtask

  always @(negedge clk) begin
    m_e = '0;
    if (!rst_n) begin
      plan.delete();
    end else begin
      if (plan.size() != 0) begin
        m_e = plan.pop_front();
        if (m_e.rd | m_e.wr) check("m_mem_addr", 64'(bus.mem_addr), 64'(m_e.addr));
        if (m_e.wr) check("m_mem_wdata", bus.mem_wdata, m_e.wdata);
        if (m_e.idone | m_e.ddone) check("m_fill_data", bus.fill_data, prev_rdata);
      end else if (bus.d_req) begin
        if (bus.d_dirty) push_burst(1'b0, bus.d_wb_addr, bus.d_wb_data);
        push_burst(1'b1, bus.d_addr, '0);
        push_done(1'b0);
      end else if (bus.i_req) begin
        push_burst(1'b1, bus.i_addr, '0);
        push_done(1'b1);
      end
      check("m_mem_rd", 64'(bus.mem_rd), 64'(m_e.rd));
      check("m_mem_wr", 64'(bus.mem_wr), 64'(m_e.wr));
      check("m_i_done", 64'(bus.i_done), 64'(m_e.idone));
      check("m_d_done", 64'(bus.d_done), 64'(m_e.ddone));
    end
    check("m_stall_if",  64'(bus.stall_if),  64'(bus.i_req & ~m_e.idone));
    check("m_stall_mem", 64'(bus.stall_mem), 64'(bus.d_req & ~m_e.ddone));
    prev_rdata = bus.mem_rdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.mem_rdata  = {$urandom, $urandom};
    bus1.mem_rdata = {$urandom, $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  64'(bus.mem_addr), 64'h0);
    check({tag, "_wdata"}, bus.mem_wdata,     64'h0);
    check({tag, "_rd"},    64'(bus.mem_rd),   64'h0);
    check({tag, "_wr"},    64'(bus.mem_wr),   64'h0);
    check({tag, "_fill"},  bus.fill_data,     64'h0);
    check({tag, "_idone"}, 64'(bus.i_done),   64'h0);
    check({tag, "_ddone"}, 64'(bus.d_done),   64'h0);
  endtask

  logic [LW-1:0] r_snap;

  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_addr = '0; bus.d_dirty = 0;
    bus.d_wb_addr = '0; bus.d_wb_data = '0; bus.mem_rdata = '0;
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_addr = '0; bus1.d_dirty = 0;
    bus1.d_wb_addr = '0; bus1.d_wb_data = '0; bus1.mem_rdata = '0;

    // Reset held, then released with no request.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    check("rst_stall_if", 64'(bus.stall_if), 64'h0);
    rst_n = 1'b1;
    step(); step();
    check_all_zero("rst_idle");

    // I fill at 0x0123.
    step();
    bus.i_req = 1; bus.i_addr = 14'h0123;
    for (int c = 1; c <= L; c++) begin
      step();
      check("if_rd",   64'(bus.mem_rd),   64'h1);
      check("if_addr", 64'(bus.mem_addr), 64'h0123);
      if (c == L) r_snap = bus.mem_rdata;
    end
    step();
    check("if_done",  64'(bus.i_done),   64'h1);
    check("if_rd_lo", 64'(bus.mem_rd),   64'h0);
    check("if_fill",  bus.fill_data,     r_snap);
    check("if_stall", 64'(bus.stall_if), 64'h0);
    bus.i_req = 0;
    step();
    check("if_done_pulse", 64'(bus.i_done), 64'h0);

    // Dirty D miss; inputs scrambled after grant must be ignored.
    bus.d_req = 1; bus.d_dirty = 1; bus.d_addr = 14'h0040;
    bus.d_wb_addr = 14'h1040; bus.d_wb_data = 64'hDEAD_BEEF_0000_0001;
    step();
    bus.d_addr = 14'h3FFF; bus.d_wb_addr = '0; bus.d_wb_data = '0; bus.d_dirty = 0;
    for (int c = 1; c <= 2 * L; c++) begin
      if (c > 1) step();
      if (c <= L) begin
        check("wb_wr",    64'(bus.mem_wr),   64'h1);
        check("wb_rd",    64'(bus.mem_rd),   64'h0);
        check("wb_addr",  64'(bus.mem_addr), 64'h1040);
        check("wb_wdata", bus.mem_wdata,     64'hDEAD_BEEF_0000_0001);
      end else begin
        check("fd_rd",   64'(bus.mem_rd),   64'h1);
        check("fd_wr",   64'(bus.mem_wr),   64'h0);
        check("fd_addr", 64'(bus.mem_addr), 64'h0040);
      end
    end
    step();
    check("fd_done", 64'(bus.d_done), 64'h1);
    bus.d_req = 0;
    step();

    // Simultaneous clean D and I: D first, one IDLE cycle, then I.
    bus.d_req = 1; bus.d_dirty = 0; bus.d_addr = 14'h0222;
    bus.i_req = 1; bus.i_addr = 14'h0333;
    repeat (L + 1) step();
    check("sim_d_done",  64'(bus.d_done),   64'h1);
    check("sim_stall5",  64'(bus.stall_if), 64'h1);
    bus.d_req = 0;
    step();
    check("sim_idle_rd", 64'(bus.mem_rd),   64'h0);
    check("sim_stall6",  64'(bus.stall_if), 64'h1);
    step();
    check("sim_i_rd",    64'(bus.mem_rd),   64'h1);
    check("sim_i_addr",  64'(bus.mem_addr), 64'h0333);
    repeat (L) step();
    check("sim_i_done",  64'(bus.i_done),   64'h1);
    bus.i_req = 0;
    step();

    // I request dropped in cycle 2 still completes.
    bus.i_req = 1; bus.i_addr = 14'h0ABC;
    step(); step();
    bus.i_req = 0;
    check("fl_rd2",  64'(bus.mem_rd), 64'h1);
    step(); step();
    check("fl_rd4",  64'(bus.mem_rd), 64'h1);
    step();
    check("fl_done", 64'(bus.i_done), 64'h1);
    step();

    // Reset in cycle 2 of a writeback, then restart from WB.
    bus.d_req = 1; bus.d_dirty = 1; bus.d_addr = 14'h0040;
    bus.d_wb_addr = 14'h1040; bus.d_wb_data = 64'hDEAD_BEEF_0000_0001;
    step(); step();
    check("rw_wr_before", 64'(bus.mem_wr), 64'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rw_rst");
    step();
    rst_n = 1'b1;
    step();
    check("rw_restart_wr",   64'(bus.mem_wr),   64'h1);
    check("rw_restart_addr", 64'(bus.mem_addr), 64'h1040);
    repeat (2 * L) step();
    check("rw_done", 64'(bus.d_done), 64'h1);
    bus.d_req = 0;
    step();

    // MEM_LAT=1 instance: one-cycle bursts, no counter wrap.
    bus1.i_req = 1; bus1.i_addr = 14'h0055;
    step();
    check("l1_rd",   64'(bus1.mem_rd),   64'h1);
    check("l1_addr", 64'(bus1.mem_addr), 64'h0055);
    r_snap = bus1.mem_rdata;
    step();
    check("l1_done", 64'(bus1.i_done),   64'h1);
    check("l1_rdlo", 64'(bus1.mem_rd),   64'h0);
    check("l1_fill", bus1.fill_data,     r_snap);
    bus1.i_req = 0;
    step();
    bus1.d_req = 1; bus1.d_dirty = 1; bus1.d_addr = 14'h0666; bus1.d_wb_addr = 14'h0777;
    step();
    check("l1_wb_wr",   64'(bus1.mem_wr),   64'h1);
    check("l1_wb_addr", 64'(bus1.mem_addr), 64'h0777);
    step();
    check("l1_fd_rd",   64'(bus1.mem_rd),   64'h1);
    check("l1_fd_wr",   64'(bus1.mem_wr),   64'h0);
    check("l1_fd_addr", 64'(bus1.mem_addr), 64'h0666);
    step();
    check("l1_d_done",  64'(bus1.d_done),   64'h1);
    check("l1_rd_lo",   64'(bus1.mem_rd),   64'h0);
    bus1.d_req = 0;

    // Randomized traffic with flushes, changing addresses and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (bus.i_req && bus.i_done)                        bus.i_req = 0;
      else if (bus.i_req && $urandom_range(0, 63) == 0)   bus.i_req = 0;
      else if (!bus.i_req && !bus.i_done && $urandom_range(0, 3) == 0) bus.i_req = 1;
      if (bus.d_req && bus.d_done)                        bus.d_req = 0;
      else if (bus.d_req && $urandom_range(0, 63) == 0)   bus.d_req = 0;
      else if (!bus.d_req && !bus.d_done && $urandom_range(0, 5) == 0) bus.d_req = 1;
      bus.i_addr    = AW'($urandom);
      bus.d_addr    = AW'($urandom);
      bus.d_wb_addr = AW'($urandom);
      bus.d_wb_data = {$urandom, $urandom};
      bus.d_dirty   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end

    bus.i_req = 0; bus.d_req = 0;
    repeat (3 * L + 4) step();
    check("drain_rd", 64'(bus.mem_rd), 64'h0);
    check("drain_wr", 64'(bus.mem_wr), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
